decoder38_scan: RTL and testbench
=================================

Name: decoder38_scan

Overview:
- Registered 3-to-8 one-hot decoder. It is the decode side of the 8-to-3 priority-free encoder.
- Two modes:
  - Direct: loads a 3-bit index from the producer and presents it as a one-hot select.
  - Scan: auto-increments the index at a prescaled rate. Used as the digit/row strobe for the 8-digit seven-segment display and LED scan logic.
- Its one-hot output fed back through the 8-to-3 encoder must return oIndex.

Parameters:
- DIV, 100000: clock cycles per scan step; legal range 1..2^24-1.
- ACTIVE_LOW, 0: 1 inverts oData, so the selected bit is 0 and idle is 8'hFF.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- iEn  input  1  output enable; 0 blanks oData and freezes scanning.
- iMode  input  1  0 = direct, 1 = scan.
- iValid  input  1  load strobe for iData, one cycle.
- iData  input  3  index to load.
- oData  output  8  registered one-hot select (polarity per ACTIVE_LOW).
- oIndex  output  3  current registered index.
- oStep  output  1  one-cycle pulse on the cycle oIndex advanced in scan mode.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk. No other state changes in a cycle where rst=1.
- Reset values:
  - oIndex=3'd0, oStep=0, prescaler=0.
  - oData=8'h00, or 8'hFF when ACTIVE_LOW=1. Outputs are blanked until the first enabled cycle.
- All outputs are registered; no combinational input-to-output path.
- Decode rule: when enabled, oData = 8'b1 << oIndex, XOR 8'hFF when ACTIVE_LOW=1. Exactly one bit is active; never zero-hot or multi-hot while iEn=1.
- Enable: iEn=0 at edge N gives blank oData from N+1.
  - oIndex is held and the prescaler is frozen (not cleared).
  - iValid is still accepted.
  - iEn rising gives the decode of the held oIndex one cycle later.
- Direct mode (iMode=0):
  - iValid=1 at edge N: oIndex=iData and oData=decode(iData) at N+1. Latency is one cycle.
  - iValid=0: hold.
  - The prescaler stays at 0 and oStep stays 0.
- Scan mode (iMode=1, iEn=1):
  - The prescaler counts 0..DIV-1.
  - On the cycle it equals DIV-1 it wraps to 0, oIndex increments mod 8 (7 wraps to 0), and oData updates on the same edge.
  - oStep is 1 for exactly the following cycle.
  - DIV=1 steps every cycle, with oStep continuously 1.
- Simultaneous iValid and prescaler terminal count in scan mode: the load wins. oIndex=iData, prescaler cleared to 0, oStep=0. The next step occurs DIV cycles later.
- Mode change: any edge where iMode differs from its registered value clears the prescaler. No step is taken on that edge; oIndex is unchanged unless iValid=1.
- Reset mid-scan: the next cycle shows the reset values and the prescaler restarts from 0. oStep never stretches across reset.
- Prescaler width: clog2(DIV) bits, minimum 1. The compare is done at full width with no truncation.

Decomposition:
- Shared package/header:
  - DEC_IN_W=3, DEC_OUT_W=8.
  - Mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - Blank patterns for both polarities.
  - These are also used by the encoder and display modules.
- Sub-module: tick_gen.
  - Parameter DIV; inputs clk, rst, iClr, iRun; output oTick.
  - oTick is asserted on the terminal count.
  - Reused by other scan/debounce blocks.
- The decoder core is the top-level index register plus the decode/polarity logic.

Test Plan:
- Reset, then direct mode with iEn=1, iValid pulse with iData=3'd5 → oData=8'b0010_0000 and oIndex=5 one cycle later; encoder83(oData)=3'd5. Repeat for all 8 values.
- Scan mode with DIV=4, run 40 cycles → oIndex sequence 0,1,...,7,0,1 with each value held 4 cycles. oStep pulses every 4th cycle; 7→0 wrap observed; oData always one-hot.
- Scan mode with DIV=4: assert iValid with iData=3'd6 on a terminal-count cycle → oIndex=6 and oStep=0 next cycle; next advance to 7 occurs exactly 4 cycles later.
- iEn=0 for 10 cycles mid-scan at oIndex=3 → oData=8'h00 and oIndex stays 3. iEn back to 1 → oData=8'b0000_1000 next cycle, and the remaining prescaler count resumes.
- ACTIVE_LOW=1, direct load of 3'd0 → oData=8'b1111_1110. iEn=0 → 8'hFF. rst → 8'hFF.
- rst asserted for 1 cycle mid-scan at oIndex=4 → oIndex=0, oStep=0, oData blank; the first step occurs DIV cycles after rst is released.

Source files
------------

// File: rtl/decoder38_scan_pkg.sv
// Shared definitions for the 3-to-8 decoder, the matching 8-to-3 encoder and
// the display/LED scan blocks.
//   - decoder index/select widths
//   - mode encodings (direct load vs. auto scan)
//   - blank patterns for active-high and active-low select lines
//   - one-hot decode helper and prescaler width helper
package decoder38_scan_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam logic [DEC_OUT_W-1:0] BLANK_ACTIVE_HIGH = 8'h00;
  localparam logic [DEC_OUT_W-1:0] BLANK_ACTIVE_LOW  = 8'hFF;

  // Active-high one-hot select for an index.
  function automatic logic [DEC_OUT_W-1:0] dec_onehot(input logic [DEC_IN_W-1:0] idx);
    return DEC_OUT_W'(1) << idx;
  endfunction

  // Counter width for a divide-by-div prescaler; never narrower than 1 bit.
  function automatic int cnt_width(input int unsigned div);
    if (div <= 1) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/decoder38_scan_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle terminal-count tick.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, counter to 0
//   iClr  : synchronous clear, counter to 0 (overrides iRun, no tick)
//   iRun  : count enable; when low the counter is frozen
//   oTick : high while running and the counter sits at DIV-1
module tick_gen
  import decoder38_scan_pkg::*;
#(
  parameter int unsigned DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic iClr,
  input  logic iRun,
  output logic oTick
);

  localparam int CNT_W = cnt_width(DIV);
  // Terminal value at full counter width; DIV-1 always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term;

  assign term  = (cnt_q == TERM);
  assign oTick = iRun & ~iClr & term;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (iRun) begin
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder38_scan.sv
// decoder38_scan: registered 3-to-8 one-hot decoder with direct-load and
// prescaled auto-scan modes (digit/row strobe for display and LED scanning).
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   iEn    : output enable; 0 blanks oData and freezes scanning
//   iMode  : 0 = direct, 1 = scan
//   iValid : one-cycle load strobe for iData
//   iData  : index to load
//   oData  : registered one-hot select (inverted when ACTIVE_LOW=1)
//   oIndex : current registered index
//   oStep  : one-cycle pulse after each scan advance
module decoder38_scan
  import decoder38_scan_pkg::*;
#(
  parameter int unsigned DIV        = 100000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iEn,
  input  logic                 iMode,
  input  logic                 iValid,
  input  logic [DEC_IN_W-1:0]  iData,
  output logic [DEC_OUT_W-1:0] oData,
  output logic [DEC_IN_W-1:0]  oIndex,
  output logic                 oStep
);

  localparam logic [DEC_OUT_W-1:0] POL_MASK = ACTIVE_LOW ? BLANK_ACTIVE_LOW : BLANK_ACTIVE_HIGH;

  mode_e                mode_q;
  mode_e                mode_in;
  logic [DEC_IN_W-1:0]  index_q, index_d;
  logic [DEC_OUT_W-1:0] data_q, data_d;
  logic                 step_q;
  logic                 mode_chg;
  logic                 pre_clr;
  logic                 pre_run;
  logic                 tick;

  assign mode_in  = mode_e'(iMode);
  assign mode_chg = (mode_in != mode_q);

  // The prescaler restarts on a mode change or a load (a load beats a
  // simultaneous terminal count), and is parked at 0 in direct mode.
  assign pre_clr = mode_chg | iValid | (mode_in == MODE_DIRECT);
  assign pre_run = iEn & (mode_in == MODE_SCAN);

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .iClr  (pre_clr),
    .iRun  (pre_run),
    .oTick (tick)
  );

  always_comb begin
    index_d = index_q;
    if (iValid) begin
      index_d = iData;
    end else if (tick) begin
      index_d = index_q + DEC_IN_W'(1);
    end
    // Decode the next index so the select changes on the same edge as oIndex.
    data_d = iEn ? (dec_onehot(index_d) ^ POL_MASK) : POL_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
      data_q  <= POL_MASK;
      step_q  <= 1'b0;
      // Track the live mode through reset so releasing reset never looks
      // like a mode change and delays the first scan step.
      mode_q  <= mode_in;
    end else begin
      index_q <= index_d;
      data_q  <= data_d;
      step_q  <= tick;
      mode_q  <= mode_in;
    end
  end

  assign oData  = data_q;
  assign oIndex = index_q;
  assign oStep  = step_q;

endmodule

// File: tb/tb_decoder38_scan.sv
module tb_decoder38_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       iEn;
  logic       iMode;
  logic       iValid;
  logic [2:0] iData;

  logic [7:0] data4, data_al, data1;
  logic [2:0] idx4, idx_al, idx1;
  logic       stp4, stp_al, stp1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder38_scan #(.DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .iEn(iEn), .iMode(iMode), .iValid(iValid), .iData(iData),
    .oData(data4), .oIndex(idx4), .oStep(stp4)
  );

  decoder38_scan #(.DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .iEn(iEn), .iMode(iMode), .iValid(iValid), .iData(iData),
    .oData(data_al), .oIndex(idx_al), .oStep(stp_al)
  );

  decoder38_scan #(.DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst(rst), .iEn(iEn), .iMode(iMode), .iValid(iValid), .iData(iData),
    .oData(data1), .oIndex(idx1), .oStep(stp1)
  );

  // Hand-written one-hot table, index -> select.
  logic [7:0] onehot_tbl [8];
  initial begin
    onehot_tbl[0] = 8'b0000_0001; onehot_tbl[1] = 8'b0000_0010;
    onehot_tbl[2] = 8'b0000_0100; onehot_tbl[3] = 8'b0000_1000;
    onehot_tbl[4] = 8'b0001_0000; onehot_tbl[5] = 8'b0010_0000;
    onehot_tbl[6] = 8'b0100_0000; onehot_tbl[7] = 8'b1000_0000;
  end

  // Reference 8-to-3 encoder; returns 4'b1000 when the input is not one-hot.
  function automatic logic [3:0] enc83(input logic [7:0] v);
    logic [3:0] r;
    int         n;
    r = 4'b1000;
    n = 0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) begin
        r = 4'(b);
        n++;
      end
    end
    if (n != 1) r = 4'b1000;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_idx;

  initial begin
    rst = 1'b1; iEn = 1'b0; iMode = 1'b0; iValid = 1'b0; iData = 3'd0;
    #1;
    cyc(); cyc();
    check("rst_data",    32'(data4),   32'h00);
    check("rst_index",   32'(idx4),    32'd0);
    check("rst_step",    32'(stp4),    32'd0);
    check("rst_data_al", 32'(data_al), 32'hFF);

    // Direct mode: every index, one-cycle latency, encoder round trip.
    rst = 1'b0; iEn = 1'b1; iMode = 1'b0;
    cyc();
    check("enable_blank_to_idx0", 32'(data4), 32'h01);
    for (int v = 0; v < 8; v++) begin
      iValid = 1'b1; iData = 3'(v);
      cyc();
      iValid = 1'b0;
      check($sformatf("dir_idx%0d", v),  32'(idx4),        32'(v));
      check($sformatf("dir_data%0d", v), 32'(data4),       32'(onehot_tbl[v]));
      check($sformatf("dir_enc%0d", v),  32'(enc83(data4)), 32'(v));
      check($sformatf("dir_step%0d", v), 32'(stp4),        32'd0);
    end
    cyc();
    check("dir_hold_idx",  32'(idx4),  32'd7);
    check("dir_hold_data", 32'(data4), 32'h80);

    // Scan mode from index 0; the mode-change edge itself takes no step.
    iValid = 1'b1; iData = 3'd0;
    cyc();
    iValid = 1'b0;
    iMode = 1'b1;
    cyc();
    check("modechg_idx",  32'(idx4), 32'd0);
    check("modechg_step", 32'(stp4), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      exp_idx = (k / 4) % 8;
      check($sformatf("scan_idx_k%0d", k),  32'(idx4),  32'(exp_idx));
      check($sformatf("scan_step_k%0d", k), 32'(stp4),  (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("scan_data_k%0d", k), 32'(data4), 32'(onehot_tbl[exp_idx]));
      check($sformatf("div1_step_k%0d", k), 32'(stp1),  32'd1);
    end

    // Load on a terminal-count edge: prescaler is at 0 after edge 40,
    // edges 41..43 bring it to 3, edge 44 is terminal.
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("pre_term_idx", 32'(idx4), 32'd2);
    end
    iValid = 1'b1; iData = 3'd6;
    cyc();
    iValid = 1'b0;
    check("load_wins_idx",  32'(idx4),  32'd6);
    check("load_wins_step", 32'(stp4),  32'd0);
    check("load_wins_data", 32'(data4), 32'h40);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("after_load_hold", 32'(idx4), 32'd6);
      check("after_load_nostep", 32'(stp4), 32'd0);
    end
    cyc();
    check("after_load_adv_idx",  32'(idx4), 32'd7);
    check("after_load_adv_step", 32'(stp4), 32'd1);

    // Enable freeze mid-scan at index 3 with prescaler at 2.
    iValid = 1'b1; iData = 3'd3;
    cyc();
    iValid = 1'b0;
    cyc(); cyc();
    iEn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("dis_data", 32'(data4), 32'h00);
      check("dis_idx",  32'(idx4),  32'd3);
      check("dis_step", 32'(stp4),  32'd0);
    end
    check("dis_data_al", 32'(data_al), 32'hFF);
    iEn = 1'b1;
    cyc();
    check("reen_data", 32'(data4), 32'h08);
    check("reen_idx",  32'(idx4),  32'd3);
    cyc();
    check("resume_idx",  32'(idx4), 32'd4);
    check("resume_step", 32'(stp4), 32'd1);

    // Reset mid-scan at index 4.
    cyc();
    rst = 1'b1;
    cyc();
    check("mid_rst_idx",  32'(idx4),  32'd0);
    check("mid_rst_step", 32'(stp4),  32'd0);
    check("mid_rst_data", 32'(data4), 32'h00);
    check("mid_rst_step1", 32'(stp1), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("post_rst_idx",  32'(idx4),  32'd0);
      check("post_rst_step", 32'(stp4),  32'd0);
      check("post_rst_data", 32'(data4), 32'h01);
    end
    cyc();
    check("post_rst_adv_idx",  32'(idx4), 32'd1);
    check("post_rst_adv_step", 32'(stp4), 32'd1);

    // Active-low polarity.
    iMode = 1'b0; iValid = 1'b1; iData = 3'd0;
    cyc();
    iValid = 1'b0;
    check("al_load0",   32'(data_al), 32'hFE);
    check("al_idx",     32'(idx_al),  32'd0);
    iEn = 1'b0;
    cyc();
    check("al_disable", 32'(data_al), 32'hFF);
    iEn = 1'b1; rst = 1'b1;
    cyc();
    check("al_reset",   32'(data_al), 32'hFF);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
